f_vector_sequencer: RTL



---
 rtl/f_vector_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/f_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : f_vector_sequencer
//  Description : Stimulus/response checker for the 4-input combinational
//                block f. A sweep drives a,b,c,d through the 16 input
//                vectors 0000..1111 (a is the MSB). Each vector is held for
//                SETTLE cycles and then sampled for one cycle. The captured
//                s values form a 16-bit response word, which is compared bit
//                by bit against the golden truth table EXPECTED.
//
//  Parameters  : EXPECTED  golden truth table, bit i = required s for vector i
//                SETTLE    cycles each vector is held before sampling (1..15)
//
//  Ports       : clk             system clock, rising edge
//                reset           synchronous, active-high reset
//                start           request a sweep (honoured only in IDLE)
//                s_in            output s of block f
//                a,b,c,d         vector bits 3..0 driven to f
//                busy            high while a sweep is in progress
//                done            one-cycle pulse when a sweep completes
//                pass            1 = last sweep had no mismatches
//                result          captured s per vector, bit i = vector i
//                err_count       number of mismatching vectors (0..16)
//                first_err       index of the first mismatching vector
//                first_err_valid first_err holds a real index
//
//  Revision    : 1.0  initial release
// ============================================================================
module f_vector_sequencer #(
    parameter logic [15:0] EXPECTED = 16'h212F,
    parameter int          SETTLE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err,
    output logic        first_err_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Terminal value of the settle counter while a vector is being driven.
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] c_LAST_IDX    = 4'd15;

    state_t     r_state;
    logic [3:0] r_idx;
    logic [3:0] r_settle_cnt;
    logic       w_mismatch;

    // Compare the live response against the golden bit for the current vector.
    assign w_mismatch = s_in ^ EXPECTED[r_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_idx           <= 4'd0;
            r_settle_cnt    <= 4'd0;
            {a, b, c, d}    <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            result          <= 16'd0;
            err_count       <= 5'd0;
            first_err       <= 4'd0;
            first_err_valid <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the DONE exit raises it.
            done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state         <= S_DRIVE;
                        r_idx           <= 4'd0;
                        r_settle_cnt    <= 4'd0;
                        {a, b, c, d}    <= 4'd0;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        result          <= 16'd0;
                        err_count       <= 5'd0;
                        first_err       <= 4'd0;
                        first_err_valid <= 1'b0;
                    end
                end

                S_DRIVE: begin
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_settle_cnt <= 4'd0;
                        r_state      <= S_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end

                S_SAMPLE: begin
                    result[r_idx] <= s_in;
                    if (w_mismatch) begin
                        // 16 vectors at most, so 5 bits never overflow.
                        err_count <= err_count + 5'd1;
                        if (!first_err_valid) begin
                            first_err       <= r_idx;
                            first_err_valid <= 1'b1;
                        end
                    end

                    if (r_idx == c_LAST_IDX) begin
                        r_state      <= S_DONE;
                        busy         <= 1'b0;
                        {a, b, c, d} <= 4'd0;
                    end else begin
                        // Outputs are registered, so the next vector is
                        // loaded onto a..d on the same edge idx advances.
                        r_idx        <= r_idx + 4'd1;
                        {a, b, c, d} <= r_idx + 4'd1;
                        r_state      <= S_DRIVE;
                    end
                end

                S_DONE: begin
                    // err_count already includes the final sample here.
                    done    <= 1'b1;
                    pass    <= (err_count == 5'd0);
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
